multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style sequencer for the multicycle CPU datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the instruction-register write strobe that latches opcode, Rs, Rt, Rd and imm into the decoder. Also drives the PC, memory, ALU-source and register-file strobes.
- Handles memory wait states with a ready handshake and keeps a wrapping retired-instruction counter.

Parameters:
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset. One clock; reset is asynchronous and active-low.
- opcode  in  6  opcode from instruction decoder; valid from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current read/write this cycle.
- ir_write  out  1  instruction decoder latch enable.
- pc_en  out  1  PC register write enable.
- pc_src  out  2  0=ALU result, 1=ALUOut register, 2=jump target.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- i_or_d  out  1  0=PC address, 1=ALUOut address.
- alu_src_a  out  1  0=PC, 1=reg A.
- alu_src_b  out  2  0=reg B, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2.
- alu_op  out  2  0=add, 1=sub, 2=funct-controlled.
- reg_dst  out  1  0=Rt, 1=Rd.
- mem_to_reg  out  1  0=ALUOut, 1=MDR.
- reg_write  out  1  register file write enable.
- halted  out  1  core stopped.
- illegal_op  out  1  one-cycle pulse on unknown opcode.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- State register is 4-bit encoded.
  - States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, ITEXE, ITWB, BRANCH, JUMP, HALT.
- Reset (rst_n=0, asynchronous):
  - state=FETCH, instr_count=0.
  - While rst_n is low, every output strobe is forced 0: ir_write, pc_en, mem_read, mem_write, reg_write, illegal_op, halted.
  - Mux selects are 0.
  - Reset mid-instruction abandons the instruction; no write strobe is issued.
- FETCH:
  - mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - Stays in FETCH while mem_ready=0, with ir_write=0 and pc_en=0.
  - In the cycle mem_ready=1: ir_write=1, pc_en=1, then go to DECODE. Only these two strobes depend on mem_ready.
- DECODE:
  - alu_src_a=0, alu_src_b=3, alu_op=0 (branch target precompute).
  - Next state by opcode:
    - 000000 -> RTEXE
    - 100011 or 101011 -> MEMADR
    - 001000 -> ITEXE
    - 000100 -> BRANCH
    - 000010 -> JUMP
    - 111111 -> HALT
    - any other opcode -> FETCH with illegal_op=1 for that one cycle. Not counted as retired.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Next: MEMRD for load, MEMWR for store.
- MEMRD: mem_read=1, i_or_d=1. Hold until mem_ready=1, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next: FETCH.
- MEMWR: mem_write=1, i_or_d=1. Hold until mem_ready=1, then go to FETCH.
- RTEXE: alu_src_a=1, alu_src_b=0, alu_op=2. Next: RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- ITEXE: alu_src_a=1, alu_src_b=2, alu_op=0. Next: ITWB.
- ITWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next: FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1.
  - pc_en=zero, sampled combinationally in the same cycle.
  - Next: FETCH.
- JUMP: pc_src=2, pc_en=1. Next: FETCH.
- HALT: halted=1, all strobes 0. Leaves only via reset.
- Retire counter:
  - instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR (mem_ready=1), RTWB, ITWB, BRANCH or JUMP.
  - Also increments once on entering HALT.
  - Wraps from 2^CNT_W-1 to 0.
- Instruction latencies with zero wait states:
  - load 5 cycles, store 4, R-type 4, addi 4, beq 3, j 3.
  - Each mem_ready=0 cycle adds one.
- mem_ready in a state that issues no memory request is ignored.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J, OP_HALT
  - state encoding constants
  - ALU_ADD/ALU_SUB/ALU_FUNCT and alu_src_b select constants
- One sub-module, ctrl_output_decode: combinational state+mem_ready+zero -> strobes/selects. Keeps the FSM next-state logic and counter separate.

Test Plan:
- Reset, then opcode=000000, mem_ready=1 held -> ir_write and pc_en pulse in cycle 1; reg_write=1, reg_dst=1 in cycle 4; instr_count=1 after 4 cycles.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> ir_write only on the ready cycle; reg_write with mem_to_reg=1 at cycle 10; no mem_read outside FETCH/MEMRD.
- beq (000100) with zero=1 then zero=0 -> pc_en=1, pc_src=1 in the BRANCH cycle for the first instruction only; both instructions counted.
- Opcode 6'b010101 -> illegal_op pulses for one cycle in DECODE, returns to FETCH, instr_count unchanged.
- Deassert rst_n asynchronously mid-MEMWR -> mem_write drops immediately; after release, state=FETCH and instr_count=0.
- CNT_W=4: run 16 addi (001000) then halt (111111) -> count wraps 15->0, reaches 1 on HALT; halted=1 stays set with all strobes 0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode, state, select encodings and the control-word bundle
// for the multicycle CPU sequencer.
package cpu_ctrl_pkg;

    localparam int unsigned OP_W    = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_HALT  = 6'b111111;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEXE  = 4'd6,
        S_RTWB   = 4'd7,
        S_ITEXE  = 4'd8,
        S_ITWB   = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_HALT   = 4'd12
    } state_t;

    localparam logic [SEL_W-1:0] ALU_ADD   = 2'd0;
    localparam logic [SEL_W-1:0] ALU_SUB   = 2'd1;
    localparam logic [SEL_W-1:0] ALU_FUNCT = 2'd2;

    localparam logic [SEL_W-1:0] SRCB_REG    = 2'd0;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'd1;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'd2;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'd2;

    typedef struct packed {
        logic             ir_write;
        logic             pc_en;
        logic [SEL_W-1:0] pc_src;
        logic             mem_read;
        logic             mem_write;
        logic             i_or_d;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             halted;
        logic             illegal_op;
    } ctrl_t;

    function automatic logic op_known(input logic [OP_W-1:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_ADDI) || (op == OP_BEQ) || (op == OP_J) ||
               (op == OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_output_decode.sv
// Combinational control word for the current sequencer state; only the
// fetch strobes, branch PC enable and illegal flag look past the state.
module ctrl_output_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t          state,
    input  logic            mem_ready,
    input  logic            zero,
    input  logic [OP_W-1:0] opcode,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_en     = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b  = SRCB_IMM_SH;
                ctrl.illegal_op = ~op_known(opcode);
            end
            S_MEMADR, S_ITEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_RTEXE: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_RTWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ITWB: begin
                ctrl.reg_write = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = PCSRC_ALUOUT;
                ctrl.pc_en     = zero;
            end
            S_JUMP: begin
                ctrl.pc_src = PCSRC_JUMP;
                ctrl.pc_en  = 1'b1;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle CPU sequencer: state register, next-state logic and the
// wrapping retired-instruction counter around the output decoder.
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [OP_W-1:0]  opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    state_t state_q;
    state_t state_d;
    logic   retire;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; retire marks the cycle an instruction completes
    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_RTEXE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_ADDI:      state_d = S_ITEXE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_HALT: begin
                        state_d = S_HALT;
                        retire  = 1'b1;
                    end
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD: begin
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_RTEXE: state_d = S_RTWB;
            S_ITEXE: state_d = S_ITWB;
            S_MEMWB, S_RTWB, S_ITWB, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

    ctrl_output_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .opcode    (opcode),
        .ctrl      (ctrl_raw)
    );

    // Reset state is FETCH, so strobes must be masked while reset is held
    assign ctrl = rst_n ? ctrl_raw : '0;

    assign ir_write   = ctrl.ir_write;
    assign pc_en      = ctrl.pc_en;
    assign pc_src     = ctrl.pc_src;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign i_or_d     = ctrl.i_or_d;
    assign alu_src_a  = ctrl.alu_src_a;
    assign alu_src_b  = ctrl.alu_src_b;
    assign alu_op     = ctrl.alu_op;
    assign reg_dst    = ctrl.reg_dst;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign reg_write  = ctrl.reg_write;
    assign halted     = ctrl.halted;
    assign illegal_op = ctrl.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: an instruction-level model
// expands each instruction into expected per-cycle control words.
module tb_multicycle_control;

    localparam int unsigned CNT_W = 4;

    typedef struct packed {
        logic             ir_write;
        logic             pc_en;
        logic [1:0]       pc_src;
        logic             mem_read;
        logic             mem_write;
        logic             i_or_d;
        logic             alu_src_a;
        logic [1:0]       alu_src_b;
        logic [1:0]       alu_op;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
        logic             halted;
        logic             illegal_op;
        logic [CNT_W-1:0] cnt;
    } obs_t;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] HLT  = 6'b111111;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             ir_write, pc_en, mem_read, mem_write, i_or_d, alu_src_a;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic             reg_dst, mem_to_reg, reg_write, halted, illegal_op;
    logic [CNT_W-1:0] instr_count;

    int               errors = 0;
    int               checks = 0;
    int               ncyc = 0;
    obs_t             exp_q[$];
    logic [CNT_W-1:0] mcnt = '0;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .ir_write    (ir_write),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .i_or_d      (i_or_d),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t s;
        s.ir_write   = ir_write;
        s.pc_en      = pc_en;
        s.pc_src     = pc_src;
        s.mem_read   = mem_read;
        s.mem_write  = mem_write;
        s.i_or_d     = i_or_d;
        s.alu_src_a  = alu_src_a;
        s.alu_src_b  = alu_src_b;
        s.alu_op     = alu_op;
        s.reg_dst    = reg_dst;
        s.mem_to_reg = mem_to_reg;
        s.reg_write  = reg_write;
        s.halted     = halted;
        s.illegal_op = illegal_op;
        s.cnt        = instr_count;
        return s;
    endfunction

    task automatic chk(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every cycle that has an expected control word queued
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e;
            e = exp_q.pop_front();
            ncyc++;
            chk($sformatf("cycle %0d", ncyc), sample(), e);
        end
    end

    function automatic logic known(input logic [5:0] op);
        return op == RT || op == LW || op == SW || op == ADDI ||
               op == BEQ || op == JMP || op == HLT;
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic obs_t base();
        obs_t b;
        b = '0;
        b.cnt = mcnt;
        return b;
    endfunction

    // Drive one cycle's inputs (entered at posedge+1) and queue its expectation
    task automatic cyc(input logic mr, input logic z, input logic [5:0] op, input obs_t e);
        mem_ready = mr;
        zero      = z;
        opcode    = op;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input logic z, input int fw,
                             input int mw, input bit rst_in_wr);
        obs_t e;
        for (int i = 0; i < fw; i++) begin
            e = base(); e.mem_read = 1; e.alu_src_b = 2'd1;
            cyc(1'b0, rbit(), 6'($urandom), e);
        end
        e = base(); e.mem_read = 1; e.alu_src_b = 2'd1; e.ir_write = 1; e.pc_en = 1;
        cyc(1'b1, rbit(), 6'($urandom), e);
        e = base(); e.alu_src_b = 2'd3; e.illegal_op = ~known(op);
        cyc(rbit(), rbit(), op, e);
        case (op)
            RT: begin
                e = base(); e.alu_src_a = 1; e.alu_op = 2'd2;
                cyc(rbit(), rbit(), op, e);
                e = base(); e.reg_write = 1; e.reg_dst = 1;
                cyc(rbit(), rbit(), op, e);
                mcnt++;
            end
            ADDI: begin
                e = base(); e.alu_src_a = 1; e.alu_src_b = 2'd2;
                cyc(rbit(), rbit(), op, e);
                e = base(); e.reg_write = 1;
                cyc(rbit(), rbit(), op, e);
                mcnt++;
            end
            LW, SW: begin
                e = base(); e.alu_src_a = 1; e.alu_src_b = 2'd2;
                cyc(rbit(), rbit(), op, e);
                for (int i = 0; i <= mw; i++) begin
                    e = base(); e.i_or_d = 1;
                    if (op == LW) e.mem_read = 1; else e.mem_write = 1;
                    if (rst_in_wr && op == SW) begin
                        mem_ready = 1'b0;
                        exp_q.push_back(e);
                        @(negedge clk);
                        #2;
                        rst_n = 1'b0;
                        #1;
                        chk("async reset mid write", sample(), obs_t'(0));
                        @(posedge clk);
                        #1;
                        chk("reset held over edge", sample(), obs_t'(0));
                        rst_n = 1'b1;
                        mcnt = '0;
                        return;
                    end
                    cyc(i == mw, rbit(), op, e);
                end
                if (op == LW) begin
                    e = base(); e.reg_write = 1; e.mem_to_reg = 1;
                    cyc(rbit(), rbit(), op, e);
                end
                mcnt++;
            end
            BEQ: begin
                e = base(); e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_src = 2'd1; e.pc_en = z;
                cyc(rbit(), z, op, e);
                mcnt++;
            end
            JMP: begin
                e = base(); e.pc_src = 2'd2; e.pc_en = 1;
                cyc(rbit(), rbit(), op, e);
                mcnt++;
            end
            HLT: mcnt++;
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        obs_t       e;
        ops = '{RT, LW, SW, ADDI, BEQ, JMP};
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("outputs during reset", sample(), obs_t'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_instr(RT, 1'b0, 0, 0, 1'b0);
        run_instr(LW, 1'b0, 2, 3, 1'b0);
        run_instr(BEQ, 1'b1, 0, 0, 1'b0);
        run_instr(BEQ, 1'b0, 1, 0, 1'b0);
        run_instr(6'b010101, 1'b0, 0, 0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            int k;
            k = $urandom_range(0, 6);
            if (k == 6) begin
                do op = 6'($urandom); while (known(op));
            end else begin
                op = ops[k];
            end
            run_instr(op, rbit(), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
        end

        run_instr(SW, 1'b0, 1, 2, 1'b1);

        for (int n = 0; n < 16; n++) begin
            run_instr(ADDI, 1'b0, $urandom_range(0, 1), 0, 1'b0);
        end
        run_instr(HLT, 1'b0, 0, 0, 1'b0);
        for (int n = 0; n < 6; n++) begin
            e = base(); e.halted = 1;
            cyc(rbit(), rbit(), 6'($urandom), e);
        end

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
